uart_rx_deframer: RTL and testbench



---
 rtl/uart_rx_deframer_pkg.sv | 20 ++
 rtl/uart_rx_deframer_if.sv | 22 ++
 rtl/uart_rx_deframer.sv | 143 ++++++++++++++
 tb/tb_uart_rx_deframer.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/uart_rx_deframer_pkg.sv
// Shared UART receive types: FSM state encoding, error-bit positions and frame-length helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    DATA       = 3'd1,
    PARITY     = 3'd2,
    STOP       = 3'd3,
    BREAK_WAIT = 3'd4
  } rx_state_t;

  localparam int ERR_BREAK  = 0;
  localparam int ERR_PARITY = 1;
  localparam int ERR_FRAME  = 2;

  function automatic int frame_bits(input int dataBits, input int parityBit, input int stopBits);
    return 1 + dataBits + parityBit + stopBits;
  endfunction

endpackage

// File: rtl/uart_rx_deframer_if.sv
// Line/FIFO side signals of the UART receiver; master drives the line, slave is the deframer.
interface uart_rx_if #(parameter int DATA_BITS = 8);

  logic                 Rx;
  logic                 Rx_Stop;
  logic                 RTS;
  logic [DATA_BITS-1:0] Rx_Data;
  logic                 Rx_Valid;
  logic [2:0]           Rx_Error;
  logic                 Rx_Busy;

  modport master (
    output Rx, Rx_Stop,
    input  RTS, Rx_Data, Rx_Valid, Rx_Error, Rx_Busy
  );

  modport slave (
    input  Rx, Rx_Stop,
    output RTS, Rx_Data, Rx_Valid, Rx_Error, Rx_Busy
  );

endinterface

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: one line sample per baud clock, MSB-first data, even parity,
// stop/break checking, and a one-cycle write strobe for each good byte.
module uart_rx_deframer
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_BIT = 1,
  parameter int STOP_BITS  = 2
) (
  input  logic      Clk,
  input  logic      Rst,
  uart_rx_if.slave  rx_if
);

  localparam logic [2:0] ST_IDLE       = IDLE;
  localparam logic [2:0] ST_DATA       = DATA;
  localparam logic [2:0] ST_PARITY     = PARITY;
  localparam logic [2:0] ST_STOP       = STOP;
  localparam logic [2:0] ST_BREAK_WAIT = BREAK_WAIT;

  localparam int CW = $clog2((DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS) + 1;

  logic [2:0]           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 par_q, par_d;
  logic                 zero_q, zero_d;
  logic                 ferr_q, ferr_d;
  logic                 valid_q, valid_d;
  logic [2:0]           err_q, err_d;
  logic                 rts_q;
  logic                 zeroNow, ferrNow, perrNow;

  // zero_q tracks "every bit so far was 0" so a break can be told apart from a bad frame.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    data_d  = data_q;
    par_d   = par_q;
    zero_d  = zero_q;
    ferr_d  = ferr_q;
    valid_d = 1'b0;
    err_d   = err_q;
    zeroNow = zero_q & ~rx_if.Rx;
    ferrNow = ferr_q | ~rx_if.Rx;
    perrNow = (PARITY_BIT != 0) && (par_q != ^shift_q);
    case (state_q)
      ST_IDLE: begin
        if (!rx_if.Rx) begin
          state_d = ST_DATA;
          cnt_d   = CW'(DATA_BITS - 1);
          err_d   = '0;
          zero_d  = 1'b1;
          ferr_d  = 1'b0;
          par_d   = 1'b0;
        end
      end
      ST_DATA: begin
        shift_d = {shift_q[DATA_BITS-2:0], rx_if.Rx};
        zero_d  = zeroNow;
        if (cnt_q == '0) begin
          if (PARITY_BIT != 0) begin
            state_d = ST_PARITY;
          end else begin
            state_d = ST_STOP;
            cnt_d   = CW'(STOP_BITS - 1);
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_PARITY: begin
        par_d   = rx_if.Rx;
        zero_d  = zeroNow;
        state_d = ST_STOP;
        cnt_d   = CW'(STOP_BITS - 1);
      end
      ST_STOP: begin
        zero_d = zeroNow;
        ferr_d = ferrNow;
        if (cnt_q == '0) begin
          // Last stop bit: decide the whole frame on this edge.
          if (zeroNow) begin
            err_d   = '0;
            err_d[ERR_BREAK] = 1'b1;
            state_d = ST_BREAK_WAIT;
          end else begin
            err_d[ERR_BREAK]  = 1'b0;
            err_d[ERR_PARITY] = perrNow;
            err_d[ERR_FRAME]  = ferrNow;
            state_d = ST_IDLE;
            if (!perrNow && !ferrNow) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_BREAK_WAIT: begin
        if (rx_if.Rx) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // RTS looks at the next state so it rises on the same edge the FSM returns to idle.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      par_q   <= 1'b0;
      zero_q  <= 1'b0;
      ferr_q  <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= '0;
      rts_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      par_q   <= par_d;
      zero_q  <= zero_d;
      ferr_q  <= ferr_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      rts_q   <= (state_d == ST_IDLE) && !rx_if.Rx_Stop;
    end
  end

  assign rx_if.RTS      = rts_q;
  assign rx_if.Rx_Data  = data_q;
  assign rx_if.Rx_Valid = valid_q;
  assign rx_if.Rx_Error = err_q;
  assign rx_if.Rx_Busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed bench for uart_rx_deframer: hand-built frames with hand-computed results.
module tb_uart_rx_deframer;
  import uart_pkg::*;

  localparam int FB = frame_bits(8, 1, 2);

  logic clk;
  logic rst;
  int   checks = 0;
  int   failures = 0;
  int   validCount = 0;

  uart_rx_if #(.DATA_BITS(8)) rxIf();

  uart_rx_deframer #(.DATA_BITS(8), .PARITY_BIT(1), .STOP_BITS(2)) dut (
    .Clk   (clk),
    .Rst   (rst),
    .rx_if (rxIf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (rxIf.Rx_Valid === 1'b1) validCount++;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycles(input int n);
    rxIf.Rx = 1'b1;
    for (int i = 0; i < n; i++) tick();
  endtask

  // Sends a full frame; stopAt >= 0 raises Rx_Stop just before that bit index.
  task automatic applyStimulus(input logic [7:0] data, input logic parity, input logic [1:0] stops,
                               input int stopAt);
    logic [FB-1:0] bits;
    bits = {1'b0, data, parity, stops};
    for (int i = FB - 1; i >= 0; i--) begin
      if (stopAt == (FB - 1 - i)) rxIf.Rx_Stop = 1'b1;
      rxIf.Rx = bits[i];
      tick();
    end
  endtask

  initial begin
    rst = 1'b0;
    rxIf.Rx = 1'b1;
    rxIf.Rx_Stop = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    checkOutput("reset_rts", rxIf.RTS, 0);
    checkOutput("reset_valid", rxIf.Rx_Valid, 0);
    checkOutput("reset_err", rxIf.Rx_Error, 0);
    checkOutput("reset_busy", rxIf.Rx_Busy, 0);
    checkOutput("reset_data", rxIf.Rx_Data, 0);
    rst = 1'b1;
    tick();
    checkOutput("rts_after_release", rxIf.RTS, 1);
    checkOutput("busy_after_release", rxIf.Rx_Busy, 0);

    applyStimulus(8'h5A, 1'b0, 2'b11, -1);
    checkOutput("f5a_valid", rxIf.Rx_Valid, 1);
    checkOutput("f5a_data", rxIf.Rx_Data, 32'h5A);
    checkOutput("f5a_err", rxIf.Rx_Error, 0);
    applyStimulus(8'hC3, 1'b0, 2'b11, -1);
    checkOutput("fc3_valid", rxIf.Rx_Valid, 1);
    checkOutput("fc3_data", rxIf.Rx_Data, 32'hC3);
    idleCycles(1);
    checkOutput("valid_one_cycle", rxIf.Rx_Valid, 0);

    applyStimulus(8'hAA, 1'b1, 2'b11, -1);
    checkOutput("par_err", rxIf.Rx_Error, 3'b010);
    checkOutput("par_valid", rxIf.Rx_Valid, 0);
    checkOutput("par_data_held", rxIf.Rx_Data, 32'hC3);
    idleCycles(2);
    checkOutput("par_err_sticky", rxIf.Rx_Error, 3'b010);
    applyStimulus(8'h01, 1'b1, 2'b11, -1);
    checkOutput("f01_valid", rxIf.Rx_Valid, 1);
    checkOutput("f01_data", rxIf.Rx_Data, 32'h01);
    checkOutput("f01_err_clear", rxIf.Rx_Error, 0);
    idleCycles(1);

    applyStimulus(8'hAA, 1'b0, 2'b00, -1);
    checkOutput("frame_err", rxIf.Rx_Error, 3'b100);
    checkOutput("frame_valid", rxIf.Rx_Valid, 0);
    checkOutput("frame_data_held", rxIf.Rx_Data, 32'h01);
    idleCycles(2);

    rxIf.Rx = 1'b0;
    for (int i = 0; i < FB; i++) tick();
    checkOutput("brk_err", rxIf.Rx_Error, 3'b001);
    checkOutput("brk_valid", rxIf.Rx_Valid, 0);
    checkOutput("brk_busy", rxIf.Rx_Busy, 1);
    checkOutput("brk_rts", rxIf.RTS, 0);
    for (int i = 0; i < 5; i++) tick();
    checkOutput("brk_wait_busy", rxIf.Rx_Busy, 1);
    checkOutput("brk_wait_rts", rxIf.RTS, 0);
    idleCycles(1);
    checkOutput("brk_end_busy", rxIf.Rx_Busy, 0);
    checkOutput("brk_end_rts", rxIf.RTS, 1);
    checkOutput("brk_err_sticky", rxIf.Rx_Error, 3'b001);
    idleCycles(1);

    applyStimulus(8'h3C, 1'b0, 2'b11, 4);
    checkOutput("f3c_valid", rxIf.Rx_Valid, 1);
    checkOutput("f3c_data", rxIf.Rx_Data, 32'h3C);
    checkOutput("f3c_err", rxIf.Rx_Error, 0);
    checkOutput("f3c_rts_blocked", rxIf.RTS, 0);
    idleCycles(2);
    checkOutput("rts_stop_held", rxIf.RTS, 0);

    rxIf.Rx = 1'b0;
    tick();
    rxIf.Rx = 1'b1;
    tick();
    rxIf.Rx = 1'b0;
    tick();
    checkOutput("mid_busy", rxIf.Rx_Busy, 1);
    rst = 1'b0;
    tick();
    checkOutput("midrst_valid", rxIf.Rx_Valid, 0);
    checkOutput("midrst_busy", rxIf.Rx_Busy, 0);
    checkOutput("midrst_data", rxIf.Rx_Data, 0);
    checkOutput("midrst_err", rxIf.Rx_Error, 0);
    checkOutput("midrst_rts", rxIf.RTS, 0);
    rst = 1'b1;
    rxIf.Rx_Stop = 1'b0;
    idleCycles(2);
    checkOutput("rerelease_rts", rxIf.RTS, 1);
    checkOutput("valid_pulses", validCount, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
